// File: rtl/vdma_frame_buffer_scheduler.sv
// Frame-buffer ring scheduler for a VDMA write channel: grants buffers on SOF,
// commits them on EOF, tracks occupancy against processor releases and drops frames when full.
module vdma_frame_buffer_scheduler #(
    parameter int unsigned NUM_BUF = 4,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned SIZE_W  = 24,
    parameter int unsigned DROP_W  = 16
) (
    input  logic              sys_clk_i,
    input  logic              rstn_i,
    input  logic              vdma_ip_en_i,
    input  logic              frame_start_i,
    input  logic              frame_end_i,
    input  logic [SIZE_W-1:0] frame_size_i,
    input  logic [ADDR_W-1:0] buf_base_addr_i,
    input  logic [ADDR_W-1:0] buf_stride_i,
    input  logic              buf_release_i,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic              wr_addr_valid_o,
    output logic              frame_done_o,
    output logic [ADDR_W-1:0] done_addr_o,
    output logic [SIZE_W-1:0] done_size_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [3:0]        fill_level_o,
    output logic              buf_full_o,
    output logic              buf_empty_o,
    output logic              frame_drop_o,
    output logic [DROP_W-1:0] drop_cnt_o
);

    localparam int unsigned      IDX_W    = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BUF - 1);
    localparam logic [3:0]       FULL_LVL = 4'(NUM_BUF);

    typedef enum logic [2:0] {
        StIdle,
        StWaitSof,
        StWrite,
        StCommit,
        StDrop
    } state_e;

    state_e state_q, state_d;

    logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
    logic [3:0]        fill_q, fill_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W-1:0] done_addr_q;
    logic [SIZE_W-1:0] done_size_q;
    logic              frame_drop_q;

    logic grant;
    logic drop_hit;
    logic eof_accept;
    logic commit;
    logic release_ok;

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    function automatic logic [ADDR_W-1:0] buf_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [ADDR_W-1:0] stride,
                                                   input logic [IDX_W-1:0]  idx);
        return base + stride * ADDR_W'(idx);
    endfunction

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant      = 1'b0;
        drop_hit   = 1'b0;
        eof_accept = 1'b0;
        if (!vdma_ip_en_i) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: state_d = StWaitSof;
                StWaitSof: begin
                    if (frame_start_i) begin
                        if (buf_full_o) begin
                            state_d  = StDrop;
                            drop_hit = 1'b1;
                        end else begin
                            state_d = StWrite;
                            grant   = 1'b1;
                        end
                    end
                end
                StWrite: begin
                    if (frame_end_i) begin
                        state_d    = StCommit;
                        eof_accept = 1'b1;
                    end
                end
                StCommit: state_d = StWaitSof;
                StDrop: begin
                    if (frame_end_i) begin
                        state_d = StWaitSof;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Ring bookkeeping
    // ------------------------------------------------------------------
    // frame_done_o has already fired in COMMIT, so the commit is honoured even if
    // the block is disabled during that cycle.
    assign commit     = (state_q == StCommit);
    assign release_ok = buf_release_i && (fill_q != 4'd0);

    always_comb begin
        wr_idx_d   = commit ? idx_inc(wr_idx_q) : wr_idx_q;
        rd_idx_d   = release_ok ? idx_inc(rd_idx_q) : rd_idx_q;
        fill_d     = fill_q;
        drop_cnt_d = drop_cnt_q;
        case ({commit, release_ok})
            2'b10:   fill_d = fill_q + 4'd1;
            2'b01:   fill_d = fill_q - 4'd1;
            default: fill_d = fill_q;
        endcase
        if (drop_hit && !(&drop_cnt_q)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_idx_q     <= '0;
            rd_idx_q     <= '0;
            fill_q       <= '0;
            drop_cnt_q   <= '0;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            done_addr_q  <= '0;
            done_size_q  <= '0;
            frame_drop_q <= 1'b0;
        end else begin
            wr_idx_q     <= wr_idx_d;
            rd_idx_q     <= rd_idx_d;
            fill_q       <= fill_d;
            drop_cnt_q   <= drop_cnt_d;
            frame_drop_q <= drop_hit;
            // Tracks the index it will hold next, so rd_addr_o moves with fill_level_o.
            rd_addr_q    <= buf_addr(buf_base_addr_i, buf_stride_i, rd_idx_d);
            if (grant) begin
                wr_addr_q <= buf_addr(buf_base_addr_i, buf_stride_i, wr_idx_q);
            end
            if (eof_accept) begin
                done_addr_q <= wr_addr_q;
                done_size_q <= frame_size_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wr_addr_o       = wr_addr_q;
    assign wr_addr_valid_o = (state_q == StWrite);
    assign frame_done_o    = (state_q == StCommit);
    assign done_addr_o     = done_addr_q;
    assign done_size_o     = done_size_q;
    assign rd_addr_o       = rd_addr_q;
    assign fill_level_o    = fill_q;
    assign buf_full_o      = (fill_q == FULL_LVL);
    assign buf_empty_o     = (fill_q == 4'd0);
    assign frame_drop_o    = frame_drop_q;
    assign drop_cnt_o      = drop_cnt_q;

endmodule

// File: tb/tb_vdma_frame_buffer_scheduler.sv
// Directed plus randomized bench for vdma_frame_buffer_scheduler, checked against a
// transaction-level ring model (counts and indices, addresses from base + idx*stride).
module tb_vdma_frame_buffer_scheduler;

    localparam int NB   = 4;
    localparam int DW   = 4;
    localparam int DMAX = (1 << DW) - 1;

    logic          clk;
    logic          rstn;
    logic          en;
    logic          fs;
    logic          fe;
    logic [23:0]   fsize;
    logic [31:0]   base;
    logic [31:0]   stride;
    logic          rel;
    logic [31:0]   wr_addr;
    logic          wr_valid;
    logic          frame_done;
    logic [31:0]   done_addr;
    logic [23:0]   done_size;
    logic [31:0]   rd_addr;
    logic [3:0]    fill;
    logic          full;
    logic          empty;
    logic          frame_drop;
    logic [DW-1:0] drop_cnt;

    int tests = 0;
    int fails = 0;

    int m_wr, m_rd, m_fill, m_drops;

    vdma_frame_buffer_scheduler #(
        .NUM_BUF(NB),
        .ADDR_W (32),
        .SIZE_W (24),
        .DROP_W (DW)
    ) dut (
        .sys_clk_i      (clk),
        .rstn_i         (rstn),
        .vdma_ip_en_i   (en),
        .frame_start_i  (fs),
        .frame_end_i    (fe),
        .frame_size_i   (fsize),
        .buf_base_addr_i(base),
        .buf_stride_i   (stride),
        .buf_release_i  (rel),
        .wr_addr_o      (wr_addr),
        .wr_addr_valid_o(wr_valid),
        .frame_done_o   (frame_done),
        .done_addr_o    (done_addr),
        .done_size_o    (done_size),
        .rd_addr_o      (rd_addr),
        .fill_level_o   (fill),
        .buf_full_o     (full),
        .buf_empty_o    (empty),
        .frame_drop_o   (frame_drop),
        .drop_cnt_o     (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_addr(input int idx);
        return base + stride * 32'(idx);
    endfunction

    task automatic model_reset();
        m_wr = 0; m_rd = 0; m_fill = 0; m_drops = 0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".wr_addr"}, wr_addr, 0);
        check({tag, ".valid"}, wr_valid, 0);
        check({tag, ".done"}, frame_done, 0);
        check({tag, ".done_addr"}, done_addr, 0);
        check({tag, ".done_size"}, done_size, 0);
        check({tag, ".rd_addr"}, rd_addr, 0);
        check({tag, ".fill"}, fill, 0);
        check({tag, ".full"}, full, 0);
        check({tag, ".empty"}, empty, 1);
        check({tag, ".drop"}, frame_drop, 0);
        check({tag, ".drop_cnt"}, drop_cnt, 0);
    endtask

    task automatic check_static(input string tag);
        check({tag, ".fill"}, fill, 64'(m_fill));
        check({tag, ".full"}, full, 64'(m_fill == NB));
        check({tag, ".empty"}, empty, 64'(m_fill == 0));
        check({tag, ".rd_addr"}, rd_addr, exp_addr(m_rd));
        check({tag, ".drop_cnt"}, drop_cnt, 64'(m_drops));
    endtask

    task automatic do_release(input string tag);
        rel = 1'b1;
        tick();
        rel = 1'b0;
        if (m_fill > 0) begin
            m_rd = (m_rd + 1) % NB;
            m_fill--;
        end
        check_static(tag);
    endtask

    // One SOF..EOF transaction starting in WAIT_SOF; granted or dropped by ring occupancy.
    task automatic do_frame(input string tag, input logic [23:0] sz, input int gap,
                            input bit rel_at_commit, input bit rel_in_drop);
        logic [31:0] ea;
        fs = 1'b1;
        tick();
        fs = 1'b0;
        if (m_fill == NB) begin
            m_drops = (m_drops < DMAX) ? m_drops + 1 : DMAX;
            check({tag, ".drop_pulse"}, frame_drop, 1);
            check({tag, ".drop_nodone"}, frame_done, 0);
            check({tag, ".drop_novalid"}, wr_valid, 0);
            check({tag, ".drop_cnt"}, drop_cnt, 64'(m_drops));
            if (rel_in_drop) begin
                do_release({tag, ".rel_in_drop"});
            end
            for (int i = 0; i < gap; i++) begin
                tick();
                check({tag, ".drop_once"}, frame_drop, 0);
            end
            fsize = sz;
            fe = 1'b1;
            tick();
            fe = 1'b0;
            check({tag, ".drop_end_nodone"}, frame_done, 0);
            check({tag, ".drop_end_nopulse"}, frame_drop, 0);
            check_static({tag, ".drop_end"});
        end else begin
            ea = exp_addr(m_wr);
            check({tag, ".sof_valid"}, wr_valid, 1);
            check({tag, ".sof_addr"}, wr_addr, ea);
            check({tag, ".sof_nodrop"}, frame_drop, 0);
            for (int i = 0; i < gap; i++) begin
                fs = 1'($urandom_range(0, 1));
                tick();
                fs = 1'b0;
                check({tag, ".hold_valid"}, wr_valid, 1);
                check({tag, ".hold_addr"}, wr_addr, ea);
                check({tag, ".hold_nodone"}, frame_done, 0);
            end
            fsize = sz;
            fe = 1'b1;
            tick();
            fe = 1'b0;
            check({tag, ".done"}, frame_done, 1);
            check({tag, ".done_size"}, done_size, sz);
            check({tag, ".done_addr"}, done_addr, ea);
            check({tag, ".commit_novalid"}, wr_valid, 0);
            rel = rel_at_commit;
            tick();
            rel = 1'b0;
            if (rel_at_commit && m_fill > 0) begin
                m_rd = (m_rd + 1) % NB;
                m_fill--;
            end
            m_wr = (m_wr + 1) % NB;
            m_fill++;
            check({tag, ".done_pulse"}, frame_done, 0);
            check_static({tag, ".commit"});
        end
    endtask

    // Grants a buffer, disables mid-WRITE, re-enables; returns the aborted address.
    task automatic abort_frame(input string tag, output logic [31:0] aborted);
        if (m_fill == NB) begin
            do_release({tag, ".pre"});
        end
        fs = 1'b1;
        tick();
        fs = 1'b0;
        aborted = wr_addr;
        check({tag, ".valid"}, wr_valid, 1);
        check({tag, ".addr"}, wr_addr, exp_addr(m_wr));
        en = 1'b0;
        tick();
        check({tag, ".off_novalid"}, wr_valid, 0);
        check({tag, ".off_nodone"}, frame_done, 0);
        fe = 1'b1;
        tick();
        fe = 1'b0;
        check({tag, ".eof_ignored"}, frame_done, 0);
        check_static({tag, ".off"});
        en = 1'b1;
        tick();
        check({tag, ".reen_novalid"}, wr_valid, 0);
        check_static({tag, ".reen"});
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        #3;
        model_reset();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        tick();
    endtask

    initial begin
        logic [31:0] ab;
        rstn = 1'b0; en = 1'b0; fs = 1'b0; fe = 1'b0; rel = 1'b0; fsize = '0;
        base = 32'h1000_0000;
        stride = 32'h0080_0000;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        rstn = 1'b1;
        en = 1'b1;
        tick();
        check_static("enable");

        // 1: single frame
        do_frame("t1", 24'h1FA400, 1, 1'b0, 1'b0);
        check("t1.done_addr_abs", done_addr, 32'h1000_0000);
        check("t1.fill_abs", fill, 1);

        // 2: fill the ring, then drop
        do_frame("t2a", 24'h000100, 0, 1'b0, 1'b0);
        check("t2.addr1_abs", wr_addr, 32'h1080_0000);
        do_frame("t2b", 24'h000200, 2, 1'b0, 1'b0);
        check("t2.addr2_abs", wr_addr, 32'h1100_0000);
        do_frame("t2c", 24'h000300, 0, 1'b0, 1'b0);
        check("t2.addr3_abs", wr_addr, 32'h1180_0000);
        check("t2.full_abs", full, 1);
        do_frame("t2drop", 24'h000400, 1, 1'b0, 1'b0);
        check("t2.drop_cnt_abs", drop_cnt, 1);

        // 3: release coincident with commit
        apply_reset();
        for (int i = 0; i < 3; i++) do_frame("t3fill", 24'(i + 1), 0, 1'b0, 1'b0);
        do_frame("t3", 24'h00ABCD, 0, 1'b1, 1'b0);
        check("t3.fill_abs", fill, 3);
        check("t3.rd_addr_abs", rd_addr, 32'h1080_0000);

        // 4: release while empty, drop counter saturation, release inside a dropped frame
        apply_reset();
        do_release("t4empty");
        check("t4.rd_addr_abs", rd_addr, 32'h1000_0000);
        for (int i = 0; i < NB; i++) do_frame("t4fill", 24'h10, 0, 1'b0, 1'b0);
        for (int i = 0; i < DMAX + 2; i++) do_frame("t4drop", 24'h20, 0, 1'b0, 1'b0);
        check("t4.sat_abs", drop_cnt, 64'(DMAX));
        do_frame("t4dropfree", 24'h30, 1, 1'b0, 1'b1);
        do_frame("t4after", 24'h40, 0, 1'b0, 1'b0);

        // 5: disable mid-WRITE, resume on the same buffer
        abort_frame("t5", ab);
        do_frame("t5resume", 24'h55, 1, 1'b0, 1'b0);
        check("t5.same_addr", done_addr, ab);

        // 6: asynchronous reset mid-WRITE
        if (m_fill == NB) do_release("t6pre");
        fs = 1'b1;
        tick();
        fs = 1'b0;
        check("t6.valid", wr_valid, 1);
        #2;
        rstn = 1'b0;
        #1;
        check_reset("t6async");
        model_reset();
        @(posedge clk);
        #1;
        check_reset("t6held");
        rstn = 1'b1;
        tick();
        check_static("t6after");

        // Randomized phase with new ring geometry loaded under reset
        rstn = 1'b0;
        base = $urandom();
        stride = $urandom();
        apply_reset();
        check_static("rnd.start");
        for (int n = 0; n < 200; n++) begin
            int op;
            op = int'($urandom_range(0, 9));
            if (op <= 4) begin
                do_frame("rnd.frame", 24'($urandom()), int'($urandom_range(0, 3)),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else if (op <= 7) begin
                do_release("rnd.rel");
            end else if (op == 8) begin
                abort_frame("rnd.abort", ab);
            end else begin
                tick();
                check("rnd.idle_nodone", frame_done, 0);
                check_static("rnd.idle");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
